io_walker_seq: RTL and testbench

Parametrised, sequenced solder-joint checker for board bring-up. Walks a one-hot (or one-cold) pattern across `NUM_PINS` test pins, waits a programmable settle time per step, samples the looped-back result pins, and reports pass/fail. It also records the failing-step count, the first failing step and the first mismatch mask. It sits between the bring-up top level (buttons/LEDs/UART) and the pins under test, and supports single-pass and continuous operation.

---
 rtl/io_walker_seq.sv | 161 ++++++++++++++++
 tb/tb_io_walker_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_walker_seq.sv
// Walks a one-hot / one-cold pattern across the pins under test, samples the
// looped-back pins after a settle delay and keeps pass/fail and first-error status.
module io_walker_seq #(
    parameter int NUM_PINS      = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        mode_i,
    input  logic                        loop_i,
    output logic [NUM_PINS-1:0]         test_pins,
    input  logic [NUM_PINS-1:0]         result_pins,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic                        error_o,
    output logic [ERR_W-1:0]            err_count_o,
    output logic [$clog2(NUM_PINS)-1:0] first_err_idx_o,
    output logic [NUM_PINS-1:0]         first_err_mask_o
);

    localparam int IDX_W = $clog2(NUM_PINS);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PINS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [NUM_PINS-1:0]   pins_q, pins_d;
    logic                  error_q, error_d;
    logic [ERR_W-1:0]      err_count_q, err_count_d;
    logic [IDX_W-1:0]      first_idx_q, first_idx_d;
    logic [NUM_PINS-1:0]   first_mask_q, first_mask_d;
    logic                  pass_fail_q, pass_fail_d;
    logic [NUM_PINS-1:0]   mismatch;

    function automatic logic [NUM_PINS-1:0] pattern(input logic [IDX_W-1:0] k,
                                                     input logic            m);
        logic [NUM_PINS-1:0] one_hot;
        one_hot = NUM_PINS'(1) << k;
        return m ? ~one_hot : one_hot;
    endfunction

    assign mismatch = result_pins ^ pattern(idx_q, mode_q);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        error_d      = error_q;
        err_count_d  = err_count_q;
        first_idx_d  = first_idx_q;
        first_mask_d = first_mask_q;
        pass_fail_d  = pass_fail_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d       = mode_i;
                    error_d      = 1'b0;
                    err_count_d  = '0;
                    first_idx_d  = '0;
                    first_mask_d = '0;
                    idx_d        = '0;
                    cnt_d        = '0;
                    pass_fail_d  = 1'b0;
                    state_d      = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                if (|mismatch) begin
                    pass_fail_d = 1'b1;
                    error_d     = 1'b1;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    // The sticky error flag doubles as "a failure was already recorded".
                    if (!error_q) begin
                        first_idx_d  = idx_q;
                        first_mask_d = mismatch;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                pass_fail_d = 1'b0;
                state_d     = loop_i ? S_DRIVE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Drive pattern is registered, so it is derived from the next step/state.
        if (state_d == S_DRIVE || state_d == S_SAMPLE) begin
            pins_d = pattern(idx_d, mode_d);
        end else begin
            pins_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            pins_q       <= '0;
            error_q      <= 1'b0;
            err_count_q  <= '0;
            first_idx_q  <= '0;
            first_mask_q <= '0;
            pass_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            pins_q       <= pins_d;
            error_q      <= error_d;
            err_count_q  <= err_count_d;
            first_idx_q  <= first_idx_d;
            first_mask_q <= first_mask_d;
            pass_fail_q  <= pass_fail_d;
        end
    end

    assign test_pins        = pins_q;
    assign busy_o           = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done_o           = (state_q == S_DONE);
    assign pass_o           = (state_q == S_DONE) && !pass_fail_q;
    assign error_o          = error_q;
    assign err_count_o      = err_count_q;
    assign first_err_idx_o  = first_idx_q;
    assign first_err_mask_o = first_mask_q;

endmodule

// File: tb/tb_io_walker_seq.sv
// Self-checking bench for io_walker_seq: directed scenarios plus random board faults,
// checked cycle by cycle against a pass-level reference model.
module tb_io_walker_seq;

    localparam int NP       = 4;
    localparam int SC       = 2;
    localparam int STEP     = SC + 1;
    localparam int PASS_LEN = NP * STEP;
    localparam int CNT_MAX  = 65535;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic          mode_i = 1'b0;
    logic          loop_i = 1'b0;
    logic [NP-1:0] test_pins;
    logic [NP-1:0] result_pins;
    logic          busy_o, done_o, pass_o, error_o;
    logic [15:0]   err_count_o;
    logic [1:0]    first_err_idx_o;
    logic [NP-1:0] first_err_mask_o;

    logic          sat_start = 1'b0;
    logic [NP-1:0] sat_test_pins;
    logic [NP-1:0] sat_result_pins;
    logic          sat_busy, sat_done, sat_pass, sat_error;
    logic [1:0]    sat_err_count;
    logic [1:0]    sat_first_idx;
    logic [NP-1:0] sat_first_mask;

    int            checks = 0;
    int            errors = 0;
    int            fault_kind = 0;
    logic [NP-1:0] sm = '0;
    logic [NP-1:0] sv = '0;

    int            m_count;
    logic          m_error;
    int            m_first_idx;
    logic [NP-1:0] m_first_mask;
    logic          m_mode;

    always #5 clk = ~clk;

    io_walker_seq #(.NUM_PINS(NP), .SETTLE_CYCLES(SC), .ERR_W(16)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
        .loop_i(loop_i), .test_pins(test_pins), .result_pins(result_pins),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .error_o(error_o),
        .err_count_o(err_count_o), .first_err_idx_o(first_err_idx_o),
        .first_err_mask_o(first_err_mask_o)
    );

    io_walker_seq #(.NUM_PINS(NP), .SETTLE_CYCLES(SC), .ERR_W(2)) u_sat (
        .clk_i(clk), .reset_i(reset_i), .start_i(sat_start), .mode_i(1'b0),
        .loop_i(1'b0), .test_pins(sat_test_pins), .result_pins(sat_result_pins),
        .busy_o(sat_busy), .done_o(sat_done), .pass_o(sat_pass), .error_o(sat_error),
        .err_count_o(sat_err_count), .first_err_idx_o(sat_first_idx),
        .first_err_mask_o(sat_first_mask)
    );

    // Board wiring faults applied to the looped-back pins.
    function automatic logic [NP-1:0] board(input logic [NP-1:0] tp, input int kind,
                                            input logic [NP-1:0] smask, input logic [NP-1:0] sval);
        logic [NP-1:0] r;
        r = tp;
        case (kind)
            1: begin r[1] = tp[1] | tp[2]; r[2] = tp[1] | tp[2]; end
            2: r = tp & 4'b0111;
            3: r = (tp & ~smask) | (sval & smask);
            default: r = tp;
        endcase
        return r;
    endfunction

    function automatic logic [NP-1:0] exp_pat(input int k, input logic m);
        logic [NP-1:0] oh;
        oh = 4'(1) << k;
        return m ? ~oh : oh;
    endfunction

    assign result_pins     = board(test_pins, fault_kind, sm, sv);
    assign sat_result_pins = ~sat_test_pins;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".error"}, 32'(error_o), 32'(m_error));
        chk({tag, ".count"}, 32'(err_count_o), 32'(m_count));
        chk({tag, ".first_idx"}, 32'(first_err_idx_o), 32'(m_first_idx));
        chk({tag, ".first_mask"}, 32'(first_err_mask_o), 32'(m_first_mask));
    endtask

    task automatic do_start(input logic mode);
        mode_i  = mode;
        start_i = 1'b1;
        tick();
        start_i      = 1'b0;
        m_mode       = mode;
        m_count      = 0;
        m_error      = 1'b0;
        m_first_idx  = 0;
        m_first_mask = '0;
    endtask

    // Entered at cycle 1 of a pass; leaves one cycle after the DONE cycle.
    task automatic run_pass(input bit disturb);
        logic          pass_fail;
        logic [NP-1:0] e, got;
        int            k;
        pass_fail = 1'b0;
        for (int c = 1; c <= PASS_LEN; c++) begin
            k = (c - 1) / STEP;
            e = exp_pat(k, m_mode);
            chk("pins", 32'(test_pins), 32'(e));
            chk("busy", 32'(busy_o), 32'd1);
            chk("done_early", 32'(done_o), 32'd0);
            chk_status("run");
            if (disturb && c == STEP + 1) begin
                start_i = 1'b1;
                mode_i  = ~mode_i;
            end
            if (disturb && c == STEP + 2) start_i = 1'b0;
            if ((c - 1) % STEP == SC) begin
                got = board(e, fault_kind, sm, sv);
                if (got !== e) begin
                    pass_fail = 1'b1;
                    if (!m_error) begin
                        m_first_idx  = k;
                        m_first_mask = got ^ e;
                    end
                    m_error = 1'b1;
                    if (m_count < CNT_MAX) m_count++;
                end
            end
            tick();
        end
        chk("done", 32'(done_o), 32'd1);
        chk("done_busy", 32'(busy_o), 32'd0);
        chk("done_pins", 32'(test_pins), 32'd0);
        chk("pass", 32'(pass_o), 32'(!pass_fail));
        chk_status("done");
        tick();
    endtask

    initial begin
        int n;
        tick();
        tick();
        reset_i = 1'b0;
        m_count = 0; m_error = 1'b0; m_first_idx = 0; m_first_mask = '0; m_mode = 1'b0;
        chk("rst.pins", 32'(test_pins), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.pass", 32'(pass_o), 32'd0);
        chk_status("rst");

        // Saturation: every step fails, 2-bit counter must stop at 3.
        sat_start = 1'b1;
        tick();
        sat_start = 1'b0;
        n = 1;
        while (!sat_done && n < 30) begin
            tick();
            n++;
        end
        chk("sat.latency", 32'(n), 32'(PASS_LEN + 1));
        chk("sat.count", 32'(sat_err_count), 32'd3);
        chk("sat.error", 32'(sat_error), 32'd1);
        chk("sat.pass", 32'(sat_pass), 32'd0);
        tick();

        // Clean loopback, walking one.
        fault_kind = 0;
        do_start(1'b0);
        run_pass(1'b0);

        // Bridge between pins 1 and 2.
        fault_kind = 1;
        do_start(1'b0);
        run_pass(1'b0);
        chk("s2.count", 32'(err_count_o), 32'd2);
        chk("s2.idx", 32'(first_err_idx_o), 32'd1);
        chk("s2.mask", 32'(first_err_mask_o), 32'h4);

        // Pin 3 open (stuck at 0), walking zero.
        fault_kind = 2;
        do_start(1'b1);
        run_pass(1'b0);
        chk("s3.count", 32'(err_count_o), 32'd3);
        chk("s3.idx", 32'(first_err_idx_o), 32'd0);
        chk("s3.mask", 32'(first_err_mask_o), 32'h8);

        // Loop mode, three back-to-back passes.
        fault_kind = 1;
        loop_i = 1'b1;
        do_start(1'b0);
        run_pass(1'b0);
        run_pass(1'b0);
        loop_i = 1'b0;
        run_pass(1'b0);
        chk("s4.idle_busy", 32'(busy_o), 32'd0);
        chk("s4.count", 32'(err_count_o), 32'd6);
        chk("s4.idx", 32'(first_err_idx_o), 32'd1);

        // Reset during step 2.
        do_start(1'b0);
        repeat (2 * STEP) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        m_count = 0; m_error = 1'b0; m_first_idx = 0; m_first_mask = '0;
        chk("s5.pins", 32'(test_pins), 32'd0);
        chk("s5.busy", 32'(busy_o), 32'd0);
        chk("s5.pass", 32'(pass_o), 32'd0);
        chk_status("s5");
        for (int i = 0; i < PASS_LEN; i++) begin
            chk("s5.no_done", 32'(done_o), 32'd0);
            tick();
        end
        fault_kind = 0;
        do_start(1'b0);
        run_pass(1'b0);

        // start_i and mode_i disturbed during step 1.
        fault_kind = 1;
        do_start(1'b0);
        run_pass(1'b1);

        // Random modes and stuck-at faults.
        for (int r = 0; r < 8; r++) begin
            fault_kind = int'($urandom_range(0, 3));
            sm = 4'($urandom);
            sv = 4'($urandom);
            do_start(1'($urandom_range(0, 1)));
            run_pass(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
